dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares one byte_enabled_simple_dual_port_ram (1 write port, 1 registered read port) between two masters:
//  M0 = CPU load/store unit, M1 = loader/debug DMA. The write port and the read port are arbitrated
//  independently, so one write and one read can issue in the same cycle. Returns read data with a tag.
//  Sits between the core's data-memory interface and the RAM instance.
// PARAMETERS
//  ADDR_WIDTH  8   word address width (256 words)
//  DATA_WIDTH  32  data width; must be a multiple of 8
//  BE_WIDTH    DATA_WIDTH/8  byte-enable width (derived localparam, not overridable)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-high reset
//  mN_req     in   1           N=0,1: request valid; held stable until mN_gnt
//  mN_we      in   1           1=write, 0=read
//  mN_addr    in   ADDR_WIDTH  word address
//  mN_wdata   in   DATA_WIDTH  write data
//  mN_be      in   BE_WIDTH    byte enables (writes only; ignored for reads)
//  mN_gnt     out  1           request accepted this cycle (combinational from req and state)
//  mN_rvalid  out  1           read data valid for master N (registered)
//  mN_rdata   out  DATA_WIDTH  read data; 0 when mN_rvalid=0
//  ram_we     out  1           RAM write enable
//  ram_be     out  BE_WIDTH    RAM byte enables
//  ram_waddr  out  ADDR_WIDTH  RAM write address
//  ram_wdata  out  DATA_WIDTH  RAM write data
//  ram_raddr  out  ADDR_WIDTH  RAM read address
//  ram_q      in   DATA_WIDTH  RAM registered read data (valid 1 cycle after raddr is sampled)
// BEHAVIOUR
//  - Reset: mN_gnt=0, mN_rvalid=0, mN_rdata=0, ram_we=0, ram_be=0; priority pointers -> M0; read pipe empty.
//  - Write arbitration: among masters with req&we, one winner per cycle; ram_we=1, ram_be/waddr/wdata from
//    winner, winner's gnt=1 same cycle. A write with be=0 is granted but drives ram_we=0.
//  - Read arbitration: among masters with req&!we, one winner per cycle; ram_raddr=winner addr, gnt=1.
//    ram_raddr holds its last value when no read issues.
//  - Read response: 1 stage. At the edge after a read grant, rd_vld<=1, rd_tag<=winner; mN_rvalid=rd_vld&(rd_tag==N),
//    mN_rdata=ram_q in that cycle. Latency grant->rvalid = 1 cycle. Back-to-back reads give rvalid every cycle, in order.
//  - Collision: if the read winner's addr equals the write winner's addr in the same cycle, the read is NOT granted
//    (RAM would return old data); it is re-arbitrated next cycle. Write always proceeds. Pointer not advanced.
//  - Same master cannot get both ports in one cycle (it presents one request).
//  - Ungranted masters keep req asserted; arbiter never drops a held request silently.
//  - rst mid-operation: in-flight read response discarded (no rvalid after rst), pending requests re-arbitrated.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: each port's pointer toggles to the other master after every grant on that port when
//    both requested (round robin, 2-way). Loser is guaranteed grant next eligible cycle.
//  Not defined: fixed priority, M0 always wins each port; M1 may starve; pointer flops absent.
// STRUCTURE
//  - Shared header dmem_arb_defs.vh: MASTER_CPU=1'b0, MASTER_DMA=1'b1 tag constants, default width localparams.
//  - Sub-module arb2_rr: 2-requester arbiter (req[1:0] -> gnt[1:0], advance input, pointer flop under
//    DMEM_ARB_RR_EN); instantiated twice (write port, read port). Top holds collision compare and read pipe.
// TESTING
//  1 rst=1 for 2 cycles with both masters requesting -> all gnt/rvalid/ram_we=0 throughout; first gnt cycle after rst.
//  2 M0 write addr=5 wdata=32'hDEADBEEF be=4'b1111, then M1 read addr=5 -> m1_gnt, next cycle m1_rvalid=1,
//    m1_rdata=32'hDEADBEEF, m0_rvalid=0.
//  3 Same cycle M0 write addr=3 be=4'b0011 wdata=32'h0000ABCD and M1 read addr=7 -> both gnt; ram_we=1,
//    ram_raddr=7; next cycle m1_rvalid=1.
//  4 Collision: M0 write addr=9 and M1 read addr=9 same cycle -> m0_gnt=1, m1_gnt=0; next cycle m1_gnt=1;
//    cycle after m1_rdata = newly written word.
//  5 Both read continuously for 8 cycles: RR_EN -> grants alternate M0,M1,...(4 each); without -> M0 gets 8, M1 0.
//  6 Assert rst the cycle after a read grant -> no rvalid for that read; ram_be=0 during rst.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared master tags, default widths and winner-select helper for the data-memory port arbiter.
// Round-robin arbitration is enabled by defining DMEM_ARB_RR_EN; otherwise M0 has fixed priority.
package dmem_port_arbiter_pkg;

   localparam logic MASTER_CPU     = 1'b0;
   localparam logic MASTER_DMA     = 1'b1;
   localparam int   DEF_ADDR_WIDTH = 8;
   localparam int   DEF_DATA_WIDTH = 32;

   // Preferred master wins if it requests, else the other one; caller qualifies with |req.
   function automatic logic pick_winner(input logic [1:0] req, input logic pref);
      if (req[pref]) begin
         return pref;
      end
      return ~pref;
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Two-master request/response bundle (CPU load/store unit = M0, loader/debug DMA = M1).
interface dmem_port_arbiter_if
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [BE_WIDTH-1:0]   m0_be;
   logic                  m0_gnt;
   logic                  m0_rvalid;
   logic [DATA_WIDTH-1:0] m0_rdata;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [BE_WIDTH-1:0]   m1_be;
   logic                  m1_gnt;
   logic                  m1_rvalid;
   logic [DATA_WIDTH-1:0] m1_rdata;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata
   );
endinterface

// File: rtl/dmem_port_arbiter_arb2_rr.sv
// Two-requester arbiter; pointer flop exists only when DMEM_ARB_RR_EN is defined, else M0 always wins.
module dmem_port_arbiter_arb2_rr
   import dmem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt,
   output logic       winner
);

`ifdef DMEM_ARB_RR_EN
   logic ptr_reg;
   logic ptr_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= MASTER_CPU;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   // Hand priority to the loser only when both actually contended and a grant went out.
   always_comb begin
      ptr_next = ptr_reg;
      if (advance && (req == 2'b11)) begin
         ptr_next = ~winner;
      end
   end

   assign winner = pick_winner(req, ptr_reg);
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, rst, advance};
   assign winner    = pick_winner(req, MASTER_CPU);
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_gnt
         assign gnt[gi] = req[gi] & (winner == 1'(gi));
      end
   endgenerate

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one simple-dual-port byte-enabled RAM between two masters; write and read ports arbitrated
// independently, single-stage tagged read response. Define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   localparam int BE_WIDTH   = DATA_WIDTH / 8
)(
   input  logic                  clk,
   input  logic                  rst,
   dmem_port_arbiter_if.slave    bus,
   output logic                  ram_we,
   output logic [BE_WIDTH-1:0]   ram_be,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_q
);

   logic [ADDR_WIDTH-1:0] addr_v  [2];
   logic [DATA_WIDTH-1:0] wdata_v [2];
   logic [BE_WIDTH-1:0]   be_v    [2];
   logic [1:0]            req_v;
   logic [1:0]            we_v;

   assign addr_v[0]  = bus.m0_addr;
   assign addr_v[1]  = bus.m1_addr;
   assign wdata_v[0] = bus.m0_wdata;
   assign wdata_v[1] = bus.m1_wdata;
   assign be_v[0]    = bus.m0_be;
   assign be_v[1]    = bus.m1_be;
   assign req_v      = {bus.m1_req, bus.m0_req};
   assign we_v       = {bus.m1_we, bus.m0_we};

   logic [1:0] wreq;
   logic [1:0] rreq;
   logic [1:0] wgnt;
   logic [1:0] rgnt;
   logic [1:0] gnt_v;
   logic       wwin;
   logic       rwin;
   logic       write_issue;
   logic       read_cand;
   logic       collision;
   logic       read_issue;

   // Masking requests during reset keeps every grant and RAM strobe low without extra gating.
   assign wreq = req_v &  we_v & {2{~rst}};
   assign rreq = req_v & ~we_v & {2{~rst}};

   dmem_port_arbiter_arb2_rr u_warb (
      .clk     (clk),
      .rst     (rst),
      .req     (wreq),
      .advance (write_issue),
      .gnt     (wgnt),
      .winner  (wwin)
   );

   dmem_port_arbiter_arb2_rr u_rarb (
      .clk     (clk),
      .rst     (rst),
      .req     (rreq),
      .advance (read_issue),
      .gnt     (rgnt),
      .winner  (rwin)
   );

   // A read hitting the word being written this cycle would return stale data, so it waits a cycle.
   assign write_issue = |wreq;
   assign read_cand   = |rreq;
   assign collision   = write_issue & read_cand & (addr_v[rwin] == addr_v[wwin]);
   assign read_issue  = read_cand & ~collision;
   assign gnt_v       = wgnt | (rgnt & {2{read_issue}});

   assign bus.m0_gnt = gnt_v[0];
   assign bus.m1_gnt = gnt_v[1];

   always_comb begin
      ram_we    = 1'b0;
      ram_be    = '0;
      ram_waddr = '0;
      ram_wdata = '0;
      if (write_issue) begin
         ram_we    = |be_v[wwin];
         ram_be    = be_v[wwin];
         ram_waddr = addr_v[wwin];
         ram_wdata = wdata_v[wwin];
      end
   end

   logic [ADDR_WIDTH-1:0] raddr_reg;
   logic                  rd_vld_reg;
   logic                  rd_tag_reg;

   assign ram_raddr = read_issue ? addr_v[rwin] : raddr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         raddr_reg  <= '0;
         rd_vld_reg <= 1'b0;
         rd_tag_reg <= MASTER_CPU;
      end else begin
         rd_vld_reg <= read_issue;
         if (read_issue) begin
            raddr_reg  <= addr_v[rwin];
            rd_tag_reg <= rwin;
         end
      end
   end

   // Response is also squashed while rst is high so a read granted just before reset never returns.
   logic [1:0]            rvalid_v;
   logic [DATA_WIDTH-1:0] rdata_v [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         assign rvalid_v[gi] = rd_vld_reg & (rd_tag_reg == 1'(gi)) & ~rst;
         assign rdata_v[gi]  = rvalid_v[gi] ? ram_q : '0;
      end
   endgenerate

   assign bus.m0_rvalid = rvalid_v[0];
   assign bus.m1_rvalid = rvalid_v[1];
   assign bus.m0_rdata  = rdata_v[0];
   assign bus.m1_rdata  = rdata_v[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and memory contents. Honors DMEM_ARB_RR_EN.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [7:0]  ram_waddr;
   logic [31:0] ram_wdata;
   logic [7:0]  ram_raddr;
   logic [31:0] ram_q;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

   dmem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ram_we    (ram_we),
      .ram_be    (ram_be),
      .ram_waddr (ram_waddr),
      .ram_wdata (ram_wdata),
      .ram_raddr (ram_raddr),
      .ram_q     (ram_q)
   );

   // RAM environment: byte-enabled write, registered read (old data on same-cycle same address).
   logic [31:0] ram_arr [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) ram_arr[i] <= '0;
      end else if (ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) ram_arr[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_q <= ram_arr[ram_raddr];
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   int          pref_w, pref_r;
   bit          pend_v;
   int          pend_tag;
   logic [31:0] pend_data;
   int          w_win, r_win;
   bit          both_w, both_r;
   bit          e_gnt [2];
   bit          e_we, e_rd;
   logic [3:0]  e_be;
   logic [7:0]  e_waddr, e_raddr;
   logic [31:0] e_wdata;
   bit          e_rv [2];
   logic [31:0] e_rdata [2];

   task automatic drive(input int m, input bit req, input bit we, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (m == 0) begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be;
      end else begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be;
      end
   endtask

   task automatic model_comb();
      bit          wr [2];
      bit          rd [2];
      logic [7:0]  a [2];
      logic [31:0] d [2];
      logic [3:0]  b [2];
      a[0] = bus.m0_addr;  a[1] = bus.m1_addr;
      d[0] = bus.m0_wdata; d[1] = bus.m1_wdata;
      b[0] = bus.m0_be;    b[1] = bus.m1_be;
      wr[0] = !rst && bus.m0_req && bus.m0_we;
      wr[1] = !rst && bus.m1_req && bus.m1_we;
      rd[0] = !rst && bus.m0_req && !bus.m0_we;
      rd[1] = !rst && bus.m1_req && !bus.m1_we;
      both_w = wr[0] && wr[1];
      both_r = rd[0] && rd[1];
      w_win = both_w ? (RR_MODE ? pref_w : 0) : (wr[0] ? 0 : (wr[1] ? 1 : -1));
      r_win = both_r ? (RR_MODE ? pref_r : 0) : (rd[0] ? 0 : (rd[1] ? 1 : -1));
      if (w_win >= 0 && r_win >= 0) begin
         if (a[w_win] == a[r_win]) r_win = -1;
      end
      e_gnt[0] = (w_win == 0) || (r_win == 0);
      e_gnt[1] = (w_win == 1) || (r_win == 1);
      e_be    = (w_win >= 0) ? b[w_win] : 4'h0;
      e_we    = (e_be != 4'h0);
      e_waddr = (w_win >= 0) ? a[w_win] : 8'h0;
      e_wdata = (w_win >= 0) ? d[w_win] : 32'h0;
      e_rd    = (r_win >= 0);
      e_raddr = e_rd ? a[r_win] : 8'h0;
      for (int k = 0; k < 2; k++) begin
         e_rv[k]    = !rst && pend_v && (pend_tag == k);
         e_rdata[k] = e_rv[k] ? pend_data : 32'h0;
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         pref_w = 0; pref_r = 0; pend_v = 0;
         for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      end else begin
         pend_v = e_rd;
         if (e_rd) begin
            pend_tag  = r_win;
            pend_data = ref_mem[e_raddr];
            if (both_r) pref_r = 1 - r_win;
         end
         if (w_win >= 0) begin
            for (int b = 0; b < 4; b++)
               if (e_be[b]) ref_mem[e_waddr][8*b +: 8] = e_wdata[8*b +: 8];
            if (both_w) pref_w = 1 - w_win;
         end
      end
   endtask

   task automatic settle();
      #2;
      model_comb();
   endtask

   task automatic advance();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 1, 1, 8'd1, 32'h11, 4'hF);
      drive(1, 1, 0, 8'd2, 32'h0, 4'h0);
      for (int c = 0; c < 2; c++) begin
         settle();
         n_checks++;
         if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, ram_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_outputs cyc=%0d got gnt=%b%b rv=%b%b we=%b required all 0", c,
                     bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, ram_we);
         end
         n_checks++;
         if (ram_be !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_ram_be got=%h required=0", ram_be);
         end
         advance();
      end
      rst = 1'b0;
      settle();
      n_checks++;
      if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_first_gnt got=%b%b required=11", bus.m0_gnt, bus.m1_gnt);
      end
      $display("txn reset release: m0 write a=1, m1 read a=2");
      advance();
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_first_rvalid got=%b required=1", bus.m1_rvalid);
      end
      advance();
   endtask

   task automatic test_write_then_read();
      drive(0, 1, 1, 8'd5, 32'hDEADBEEF, 4'hF);
      settle();
      n_checks++;
      if (bus.m0_gnt !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 8'd5) begin
         n_fail++;
         $display("FAIL wr_grant got gnt=%b we=%b waddr=%0d required 1 1 5", bus.m0_gnt, ram_we, ram_waddr);
      end
      $display("txn m0 write a=5 d=deadbeef");
      advance();
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      drive(1, 1, 0, 8'd5, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_grant got=%b required=1", bus.m1_gnt);
      end
      advance();
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'hDEADBEEF || bus.m0_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_data got rv1=%b d=%h rv0=%b required 1 deadbeef 0",
                  bus.m1_rvalid, bus.m1_rdata, bus.m0_rvalid);
      end
      $display("txn m1 read a=5 d=%h", bus.m1_rdata);
      advance();
   endtask

   task automatic test_concurrent();
      drive(0, 1, 1, 8'd3, 32'h0000ABCD, 4'b0011);
      drive(1, 1, 0, 8'd7, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL conc_gnt got=%b%b required=11", bus.m0_gnt, bus.m1_gnt);
      end
      n_checks++;
      if (ram_we !== 1'b1 || ram_raddr !== 8'd7 || ram_be !== 4'b0011) begin
         n_fail++;
         $display("FAIL conc_ram got we=%b raddr=%0d be=%b required 1 7 0011", ram_we, ram_raddr, ram_be);
      end
      $display("txn m0 write a=3 be=0011 | m1 read a=7");
      advance();
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_rvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL conc_rvalid got=%b required=1", bus.m1_rvalid);
      end
      advance();
   endtask

   task automatic test_collision();
      drive(0, 1, 1, 8'd9, 32'h12345678, 4'hF);
      drive(1, 1, 0, 8'd9, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m0_gnt !== 1'b1 || bus.m1_gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL coll_gnt got=%b%b required=10", bus.m0_gnt, bus.m1_gnt);
      end
      $display("txn collision a=9: write proceeds, read held");
      advance();
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_regrant got=%b required=1", bus.m1_gnt);
      end
      advance();
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL coll_rdata got rv=%b d=%h required 1 12345678", bus.m1_rvalid, bus.m1_rdata);
      end
      advance();
   endtask

   task automatic test_back_to_back();
      int cnt [2];
      int prev;
      int exp_w;
      cnt[0] = 0; cnt[1] = 0; prev = -1;
      drive(0, 1, 0, 8'd10, 32'h0, 4'h0);
      drive(1, 1, 0, 8'd11, 32'h0, 4'h0);
      for (int k = 0; k < 8; k++) begin
         settle();
         exp_w = RR_MODE ? (k % 2) : 0;
         if (bus.m0_gnt === 1'b1) cnt[0]++;
         if (bus.m1_gnt === 1'b1) cnt[1]++;
         n_checks++;
         if (bus.m0_gnt !== (exp_w == 0) || bus.m1_gnt !== (exp_w == 1)) begin
            n_fail++;
            $display("FAIL b2b_gnt k=%0d got=%b%b required winner m%0d", k, bus.m0_gnt, bus.m1_gnt, exp_w);
         end
         if (prev >= 0) begin
            n_checks++;
            if ((prev == 0 ? bus.m0_rvalid : bus.m1_rvalid) !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_rvalid k=%0d got rv=%b%b required m%0d", k, bus.m0_rvalid, bus.m1_rvalid, prev);
            end
         end
         $display("txn b2b read k=%0d winner m%0d", k, bus.m1_gnt === 1'b1 ? 1 : 0);
         prev = exp_w;
         advance();
      end
      n_checks++;
      if (cnt[0] != (RR_MODE ? 4 : 8) || cnt[1] != (RR_MODE ? 4 : 0)) begin
         n_fail++;
         $display("FAIL b2b_counts got m0=%0d m1=%0d required m0=%0d m1=%0d", cnt[0], cnt[1],
                  RR_MODE ? 4 : 8, RR_MODE ? 4 : 0);
      end
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      advance();
   endtask

   task automatic test_reset_midflight();
      drive(1, 1, 0, 8'd5, 32'h0, 4'h0);
      settle();
      n_checks++;
      if (bus.m1_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_gnt got=%b required=1", bus.m1_gnt);
      end
      advance();
      rst = 1'b1;
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      drive(0, 1, 1, 8'd20, 32'hCAFEF00D, 4'hF);
      for (int c = 0; c < 2; c++) begin
         settle();
         n_checks++;
         if (bus.m1_rvalid !== 1'b0 || bus.m0_rvalid !== 1'b0 || bus.m0_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_out cyc=%0d got rv=%b%b gnt0=%b required 0", c,
                     bus.m0_rvalid, bus.m1_rvalid, bus.m0_gnt);
         end
         n_checks++;
         if (ram_be !== 4'h0 || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_ram cyc=%0d got be=%h we=%b required 0 0", c, ram_be, ram_we);
         end
         advance();
      end
      rst = 1'b0;
      settle();
      n_checks++;
      if (bus.m0_gnt !== 1'b1 || bus.m1_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_after got gnt0=%b rv1=%b required 1 0", bus.m0_gnt, bus.m1_rvalid);
      end
      $display("txn reset mid-flight: read discarded, m0 write a=20 re-granted");
      advance();
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      advance();
   endtask

   task automatic test_random(input int ncyc);
      bit          act [2];
      bit          we  [2];
      logic [7:0]  ad  [2];
      logic [31:0] wd  [2];
      logic [3:0]  be  [2];
      act[0] = 0; act[1] = 0;
      for (int c = 0; c < ncyc; c++) begin
         for (int m = 0; m < 2; m++) begin
            if (!act[m] && $urandom_range(0, 3) != 0) begin
               act[m] = 1;
               we[m]  = 1'($urandom_range(0, 1));
               ad[m]  = 8'($urandom_range(0, 7));
               wd[m]  = $urandom;
               be[m]  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            drive(m, act[m], we[m], ad[m], wd[m], be[m]);
         end
         settle();
         n_checks++;
         if (bus.m0_gnt !== e_gnt[0] || bus.m1_gnt !== e_gnt[1]) begin
            n_fail++;
            $display("FAIL rnd_gnt cyc=%0d got=%b%b required=%b%b", c, bus.m0_gnt, bus.m1_gnt, e_gnt[0], e_gnt[1]);
         end
         n_checks++;
         if (ram_we !== e_we || ram_be !== e_be) begin
            n_fail++;
            $display("FAIL rnd_wport cyc=%0d got we=%b be=%h required we=%b be=%h", c, ram_we, ram_be, e_we, e_be);
         end
         if (e_we) begin
            n_checks++;
            if (ram_waddr !== e_waddr || ram_wdata !== e_wdata) begin
               n_fail++;
               $display("FAIL rnd_wdata cyc=%0d got a=%0d d=%h required a=%0d d=%h", c,
                        ram_waddr, ram_wdata, e_waddr, e_wdata);
            end
         end
         if (e_rd) begin
            n_checks++;
            if (ram_raddr !== e_raddr) begin
               n_fail++;
               $display("FAIL rnd_raddr cyc=%0d got=%0d required=%0d", c, ram_raddr, e_raddr);
            end
         end
         n_checks++;
         if (bus.m0_rvalid !== e_rv[0] || bus.m1_rvalid !== e_rv[1]) begin
            n_fail++;
            $display("FAIL rnd_rvalid cyc=%0d got=%b%b required=%b%b", c,
                     bus.m0_rvalid, bus.m1_rvalid, e_rv[0], e_rv[1]);
         end
         n_checks++;
         if (bus.m0_rdata !== e_rdata[0] || bus.m1_rdata !== e_rdata[1]) begin
            n_fail++;
            $display("FAIL rnd_rdata cyc=%0d got=%h/%h required=%h/%h", c,
                     bus.m0_rdata, bus.m1_rdata, e_rdata[0], e_rdata[1]);
         end
         for (int m = 0; m < 2; m++) begin
            if (e_gnt[m]) begin
               $display("txn rnd cyc=%0d m%0d %s a=%0d", c, m, we[m] ? "wr" : "rd", ad[m]);
               act[m] = 0;
            end
         end
         advance();
      end
      drive(0, 0, 0, 8'd0, 32'h0, 4'h0);
      drive(1, 0, 0, 8'd0, 32'h0, 4'h0);
      settle();
      advance();
   endtask

   initial begin
      pref_w = 0; pref_r = 0; pend_v = 0; pend_tag = 0; pend_data = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      test_reset();
      test_write_then_read();
      test_concurrent();
      test_collision();
      test_back_to_back();
      test_reset_midflight();
      test_random(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
